// File: rtl/md_pkg.sv
// Shared op codes, state encoding and helpers for the mult/div issue path.
package md_pkg;

  localparam logic [2:0] MD_MFLO  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_MULT  = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_DIV   = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam logic [2:0] MD_MTHI  = 3'b110;
  localparam logic [2:0] MD_MFHI  = 3'b111;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_long(input logic [2:0] op);
    return (op == MD_MULTU) || (op == MD_MULT) ||
           (op == MD_DIVU)  || (op == MD_DIV);
  endfunction

  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Latency countdown for in-flight mult/div ops.
// last flags the commit cycle (cnt == 1).
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Mult/div issue controller: drives the HI/LO core ctrl interface.
// Optional MD_CANCEL_EN adds a cancel input for exception flush.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [2:0]  md_ctrl,
  input  logic [31:0] md_s,
  output logic [31:0] rd_data
);

  md_state_e   state;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        kill;
  logic        idle;
  logic        accept;
  logic        last;
  logic        div0;
  logic [CNT_W-1:0] lat_val;

`ifdef MD_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  assign idle    = (state == MD_IDLE);
  assign accept  = idle && req_valid && !kill && is_md_long(req_op);
  assign lat_val = is_md_div(req_op) ? CNT_W'(DIV_LAT)
                                     : CNT_W'(MULT_LAT);
  assign div0    = is_md_div(op_q) && (b_q == '0);

  md_lat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .load_val(lat_val),
    .dec     (!idle),
    .clr     (!idle && kill),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MD_IDLE;
      op_q  <= MD_MFLO;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (accept) begin
            state <= MD_RUN;
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
          end
        end
        MD_RUN: begin
          if (kill || last) state <= MD_IDLE;
        end
      endcase
    end
  end

  // Divide by zero still burns the full latency but never commits.
  always_comb begin
    req_ready = idle && !kill;
    busy      = !idle;
    md_a      = idle ? req_a : a_q;
    md_b      = idle ? req_b : b_q;
    md_ctrl   = MD_MFLO;
    unique case (state)
      MD_IDLE: begin
        if (req_valid && !kill && !is_md_long(req_op))
          md_ctrl = req_op;
      end
      MD_RUN: begin
        if (last && !kill && !div0)
          md_ctrl = op_q;
      end
    endcase
  end

  assign rd_data = md_s;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Randomized + directed bench for md_issue_ctrl with a HI/LO core stub.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        cancel;
  logic        req_ready;
  logic        busy;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [2:0]  md_ctrl;
  logic [31:0] md_s;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
`ifdef MD_CANCEL_EN
    .cancel   (cancel),
`endif
    .req_ready(req_ready),
    .busy     (busy),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_ctrl  (md_ctrl),
    .md_s     (md_s),
    .rd_data  (rd_data)
  );

  function automatic bit op_long(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic bit op_div(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

  // {hi, lo} produced by a committed mult/div
  function automatic logic [63:0] md_res(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] r;
    case (op)
      3'd1: r = {32'h0, a} * {32'h0, b};
      3'd2: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      3'd3: r = {a % b, a / b};
      3'd4: r = {32'($signed(a) % $signed(b)),
                 32'($signed(a) / $signed(b))};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  // HI/LO core stub, reacting only to the DUT's ctrl lines
  logic [31:0] c_hi = 32'h0;
  logic [31:0] c_lo = 32'h0;

  always @(posedge clk) begin
    if (op_long(md_ctrl))
      {c_hi, c_lo} <= md_res(md_ctrl, md_a, md_b, c_hi, c_lo);
    else if (md_ctrl == 3'd5)
      c_lo <= md_a;
    else if (md_ctrl == 3'd6)
      c_hi <= md_a;
  end

  assign md_s = (md_ctrl == 3'd7) ? c_hi :
                (md_ctrl == 3'd0) ? c_lo : 32'h0;

  // Reference model: remaining busy cycles plus architectural HI/LO
  int          m_left;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  int checks   = 0;
  int failures = 0;

  logic        o_ready, o_busy;
  logic [2:0]  o_ctrl;
  logic [31:0] o_rd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic eval();
    logic [2:0] ec;
    bit dz;
    o_ready = req_ready;
    o_busy  = busy;
    o_ctrl  = md_ctrl;
    o_rd    = rd_data;
    if (m_left == 0) begin
      chk("ready_idle", 32'(req_ready), 32'(!cancel));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("md_a_idle", md_a, req_a);
      chk("md_b_idle", md_b, req_b);
      ec = (req_valid && !cancel && !op_long(req_op)) ? req_op : 3'd0;
      chk("ctrl_idle", 32'(md_ctrl), 32'(ec));
      if (req_valid && !cancel && (req_op == 3'd7))
        chk("rd_mfhi", rd_data, m_hi);
      if (req_valid && !cancel && (req_op == 3'd0))
        chk("rd_mflo", rd_data, m_lo);
      if (req_valid && !cancel) begin
        if (op_long(req_op)) begin
          m_left = op_div(req_op) ? 10 : 5;
          m_op = req_op;
          m_a = req_a;
          m_b = req_b;
        end else if (req_op == 3'd5) begin
          m_lo = req_a;
        end else if (req_op == 3'd6) begin
          m_hi = req_a;
        end
      end
    end else begin
      dz = op_div(m_op) && (m_b == 32'h0);
      chk("ready_run", 32'(req_ready), 32'd0);
      chk("busy_run", 32'(busy), 32'd1);
      chk("md_a_run", md_a, m_a);
      chk("md_b_run", md_b, m_b);
      ec = (m_left == 1 && !cancel && !dz) ? m_op : 3'd0;
      chk("ctrl_run", 32'(md_ctrl), 32'(ec));
      if (cancel) begin
        m_left = 0;
      end else begin
        if (m_left == 1 && !dz)
          {m_hi, m_lo} = md_res(m_op, m_a, m_b, m_hi, m_lo);
        m_left--;
      end
    end
  endtask

  task automatic step(input bit v, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit c);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    cancel    = c;
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  // Idle until busy drops; returns busy count and commit cycle index
  task automatic run_out(output int nb, output int cc);
    nb = 0;
    cc = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      nb++;
      if (o_ctrl != 3'd0) cc = nb;
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  int nb, cc;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    cancel    = 1'b0;
    m_left = 0; m_op = 3'd0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ctrl", 32'(md_ctrl), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // mult -1 * 2
    step(1'b1, 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("mult_acc_ctrl", 32'(o_ctrl), 32'd0);
    run_out(nb, cc);
    chk("mult_busy", nb, 32'd5);
    chk("mult_commit_cyc", cc, 32'd5);
    step(1'b1, 3'd7, 32'h0, 32'h0, 1'b0);
    chk("mult_hi", o_rd, 32'hFFFFFFFF);
    step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("mult_lo", o_rd, 32'hFFFFFFFE);

    // divu 7/2 with mfhi held during busy
    step(1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'd7, 32'h0, 32'h0, 1'b0);
      if (o_ready) break;
      nb++;
    end
    chk("divu_stall", nb, 32'd10);
    chk("divu_hi", o_rd, 32'd1);
    step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("divu_lo", o_rd, 32'd3);

    // mtlo zero latency
    step(1'b1, 3'd5, 32'h1234, 32'h0, 1'b0);
    chk("mtlo_ctrl", 32'(o_ctrl), 32'd5);
    chk("mtlo_busy", 32'(o_busy), 32'd0);
    step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("mtlo_rd", o_rd, 32'h1234);

    // divide by zero leaves HI/LO
    step(1'b1, 3'd6, 32'hA, 32'h0, 1'b0);
    step(1'b1, 3'd5, 32'hB, 32'h0, 1'b0);
    step(1'b1, 3'd4, 32'd5, 32'd0, 1'b0);
    run_out(nb, cc);
    chk("div0_busy", nb, 32'd10);
    chk("div0_commit", cc, 32'd0);
    step(1'b1, 3'd7, 32'h0, 32'h0, 1'b0);
    chk("div0_hi", o_rd, 32'hA);
    step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("div0_lo", o_rd, 32'hB);

    // reset on busy cycle 3 of mult
    step(1'b1, 3'd2, 32'd3, 32'd4, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ctrl", 32'(md_ctrl), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    m_left = 0;
    step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("midrst_nocommit", o_rd, 32'hB);
    step(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
    chk("midrst_accept", 32'(o_ready), 32'd1);
    run_out(nb, cc);
    chk("multu_busy", nb, 32'd5);
    step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("multu_lo", o_rd, 32'd42);

`ifdef MD_CANCEL_EN
    step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    chk("cancel_busy", 32'(busy), 32'd0);
    step(1'b1, 3'd5, 32'd99, 32'h0, 1'b1);
    chk("cancel_idle_ready", 32'(o_ready), 32'd0);
    step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("cancel_lo", o_rd, 32'd42);
    step(1'b1, 3'd2, 32'd9, 32'd9, 1'b0);
    chk("cancel_next_acc", 32'(o_ready), 32'd1);
    run_out(nb, cc);
    chk("cancel_mult_busy", nb, 32'd5);
`endif

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bit v, c;
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 50));
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if (op == 3'd4 && b == 32'hFFFFFFFF) b = 32'd1;
      c = 1'b0;
`ifdef MD_CANCEL_EN
      c = ($urandom_range(0, 15) == 0);
`endif
      step(v, op, a, b, c);
    end
    run_out(nb, cc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
